// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte sources.
// Arbitration is round-robin per message. The winner keeps the grant until it
// sends a byte flagged last, or until it stalls for LOCK_TIMEOUT idle cycles.
// Each byte goes through IDLE -> SEND -> SETTLE, so strobes are at least 3
// cycles apart. All outputs are registered.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_strobe,
  input  logic                 tx_ready,
  output logic                 lock_dropped
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SCAN_W = IDX_W + 1;
  localparam int CNT_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_q;          // last winner; also the owner while locked
  logic                 last_q;        // req_last sampled with the committed byte
  logic                 lock_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [7:0]           tx_data_q;
  logic                 tx_strobe_q;
  logic                 lock_dropped_q;

  // Arbitration result for the current cycle.
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [7:0]           win_byte;
  logic                 win_last;
  logic [SCAN_W-1:0]    scan;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pick the winner: the locked owner only, or the first valid from rr+1 with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_q;
    scan    = '0;
    if (lock_q) begin
      win_vld = req_valid[rr_q];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan = {1'b0, rr_q} + SCAN_W'(k);
        if (scan >= SCAN_W'(NUM_REQ)) scan = scan - SCAN_W'(NUM_REQ);
        if (!win_vld && req_valid[scan[IDX_W-1:0]]) begin
          win_vld = 1'b1;
          win_idx = scan[IDX_W-1:0];
        end
      end
    end
    win_byte = req_data[{win_idx, 3'b000} +: 8];
    win_last = req_last[win_idx];
  end

  // Arbiter FSM with registered outputs, lock tracking and stall timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_q           <= RR_INIT;
      last_q         <= 1'b0;
      lock_q         <= 1'b0;
      cnt_q          <= '0;
      req_ack_q      <= '0;
      grant_q        <= '0;
      tx_data_q      <= '0;
      tx_strobe_q    <= 1'b0;
      lock_dropped_q <= 1'b0;
    end else begin
      tx_strobe_q    <= 1'b0;
      req_ack_q      <= '0;
      lock_dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lock_q && !req_valid[rr_q]) begin
            if (cnt_q == CNT_MAX) begin
              lock_q         <= 1'b0;
              grant_q        <= '0;
              lock_dropped_q <= 1'b1;
              cnt_q          <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
          end
          // The byte is committed here; the requester may drop valid afterwards.
          if (tx_ready && win_vld) begin
            tx_data_q   <= win_byte;
            last_q      <= win_last;
            rr_q        <= win_idx;
            tx_strobe_q <= 1'b1;
            req_ack_q   <= onehot(win_idx);
            grant_q     <= onehot(win_idx);
            state_q     <= SEND;
          end
        end
        SEND: begin
          lock_q  <= !last_q;
          cnt_q   <= '0;
          grant_q <= last_q ? '0 : onehot(rr_q);
          state_q <= SETTLE;
        end
        SETTLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack      = req_ack_q;
  assign grant        = grant_q;
  assign tx_data      = tx_data_q;
  assign tx_strobe    = tx_strobe_q;
  assign lock_dropped = lock_dropped_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a short lock timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ack;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic        tx_ready;
  logic        lock_dropped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ack      (req_ack),
    .grant        (grant),
    .tx_data      (tx_data),
    .tx_strobe    (tx_strobe),
    .tx_ready     (tx_ready),
    .lock_dropped (lock_dropped)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reset with all inputs idle; returns at a negedge with reset released.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int strobes;
    int ack0;
    int drop_at;

    // Reset state
    do_reset();
    reset = 1'b1;
    cyc();
    chk("rst_strobe", {15'd0, tx_strobe}, 16'd0);
    chk("rst_ack",    {14'd0, req_ack},   16'd0);
    chk("rst_grant",  {14'd0, grant},     16'd0);
    chk("rst_data",   {8'd0, tx_data},    16'd0);
    chk("rst_drop",   {15'd0, lock_dropped}, 16'd0);
    reset = 1'b0;

    // Both valid, last=1: alternating 0,1,0 every 3 cycles
    req_valid = 2'b11; req_data = 16'h2211; req_last = 2'b11;
    cyc();
    chk("alt1_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("alt1_data",   {8'd0, tx_data},    16'h11);
    chk("alt1_ack",    {14'd0, req_ack},   16'd1);
    chk("alt1_grant",  {14'd0, grant},     16'd1);
    cyc();
    chk("alt1_settle_strobe", {15'd0, tx_strobe}, 16'd0);
    chk("alt1_settle_ack",    {14'd0, req_ack},   16'd0);
    chk("alt1_settle_grant",  {14'd0, grant},     16'd0);
    cyc();
    chk("alt1_idle_strobe", {15'd0, tx_strobe}, 16'd0);
    cyc();
    chk("alt2_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("alt2_data",   {8'd0, tx_data},    16'h22);
    chk("alt2_ack",    {14'd0, req_ack},   16'd2);
    chk("alt2_grant",  {14'd0, grant},     16'd2);
    cyc(); cyc(); cyc();
    chk("alt3_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("alt3_data",   {8'd0, tx_data},    16'h11);
    chk("alt3_ack",    {14'd0, req_ack},   16'd1);

    // Locked two-byte message "AB" from req0 while req1 waits
    do_reset();
    req_valid = 2'b11; req_data = 16'h5541; req_last = 2'b10;
    cyc();
    chk("msgA_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("msgA_data",   {8'd0, tx_data},    16'h41);
    chk("msgA_ack",    {14'd0, req_ack},   16'd1);
    req_data = 16'h5542; req_last = 2'b11;
    cyc();
    chk("msgA_settle_grant", {14'd0, grant}, 16'd1);
    cyc();
    chk("msgA_idle_grant", {14'd0, grant}, 16'd1);
    cyc();
    chk("msgB_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("msgB_data",   {8'd0, tx_data},    16'h42);
    chk("msgB_ack",    {14'd0, req_ack},   16'd1);
    chk("msgB_grant",  {14'd0, grant},     16'd1);
    req_valid = 2'b10;
    cyc();
    chk("msgB_release_grant", {14'd0, grant}, 16'd0);
    cyc(); cyc();
    chk("msgC_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("msgC_data",   {8'd0, tx_data},    16'h55);
    chk("msgC_ack",    {14'd0, req_ack},   16'd2);
    chk("msgC_grant",  {14'd0, grant},     16'd2);

    // tx_ready low for 200 cycles: nothing sent; strobe one cycle after ready
    do_reset();
    tx_ready = 1'b0; req_valid = 2'b01; req_data = 16'h0033; req_last = 2'b01;
    strobes = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (tx_strobe) strobes++;
    end
    chk("notready_strobes", 16'(strobes), 16'd0);
    chk("notready_grant",   {14'd0, grant}, 16'd0);
    tx_ready = 1'b1;
    cyc();
    chk("ready_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("ready_data",   {8'd0, tx_data},    16'h33);

    // Lock timeout: req0 sends last=0 then stalls
    do_reset();
    req_valid = 2'b11; req_data = 16'h6261; req_last = 2'b10;
    cyc();
    chk("to_first_ack",  {14'd0, req_ack}, 16'd1);
    chk("to_first_data", {8'd0, tx_data},  16'h61);
    req_valid = 2'b10;
    ack0 = 0;
    drop_at = 0;
    for (int n = 2; n <= 40; n++) begin
      cyc();
      if (req_ack[0]) ack0++;
      if (n == 18) chk("to_grant_held", {14'd0, grant}, 16'd1);
      if (lock_dropped) begin
        drop_at = n;
        chk("to_grant_dropped", {14'd0, grant}, 16'd0);
        break;
      end
    end
    chk("to_drop_cycle", 16'(drop_at), 16'd19);
    chk("to_no_reack0",  16'(ack0),    16'd0);
    cyc();
    chk("to_next_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("to_next_data",   {8'd0, tx_data},    16'h62);
    chk("to_next_ack",    {14'd0, req_ack},   16'd2);
    chk("to_drop_pulse",  {15'd0, lock_dropped}, 16'd0);

    // Reset asserted during SEND
    do_reset();
    req_valid = 2'b11; req_data = 16'h7877; req_last = 2'b11;
    cyc();
    chk("rs_send_strobe", {15'd0, tx_strobe}, 16'd1);
    reset = 1'b1;
    #1;
    chk("rs_strobe_low", {15'd0, tx_strobe}, 16'd0);
    chk("rs_ack_low",    {14'd0, req_ack},   16'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("rs_after_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("rs_after_data",   {8'd0, tx_data},    16'h77);
    chk("rs_after_ack",    {14'd0, req_ack},   16'd1);

    // Single requester with last=1 wins back-to-back
    do_reset();
    req_valid = 2'b10; req_data = 16'h9900; req_last = 2'b10;
    cyc();
    chk("solo1_ack",  {14'd0, req_ack}, 16'd2);
    chk("solo1_data", {8'd0, tx_data},  16'h99);
    cyc(); cyc(); cyc();
    chk("solo2_strobe", {15'd0, tx_strobe}, 16'd1);
    chk("solo2_ack",    {14'd0, req_ack},   16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
